// File: rtl/ct_f_spsram_arb_ctrl.sv
// Access controller for one single-port SRAM macro: clears every entry after reset,
// then round-robins the single port between one read and one write requester.
module ct_f_spsram_arb_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 59
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_start,
  output logic                  init_busy,
  output logic                  init_done,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_gnt,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] w_ptr_nxt;
  logic                  r_last_wr;
  logic                  w_last_wr_nxt;
  logic                  r_rd_vld;
  logic [ADDR_WIDTH-1:0] r_a_hold;
  logic [DATA_WIDTH-1:0] r_d_hold;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state   <= ST_INIT;
      r_ptr     <= '0;
      r_last_wr <= 1'b1;
      r_rd_vld  <= 1'b0;
      r_a_hold  <= '0;
      r_d_hold  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_last_wr <= w_last_wr_nxt;
      r_rd_vld  <= rd_gnt;
      r_a_hold  <= sram_a;
      r_d_hold  <= sram_d;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_last_wr_nxt = r_last_wr;
    init_busy     = 1'b0;
    init_done     = 1'b0;
    rd_gnt        = 1'b0;
    wr_gnt        = 1'b0;
    sram_cen      = 1'b1;
    sram_gwen     = 1'b1;
    sram_wen      = '1;
    sram_a        = r_a_hold;
    sram_d        = r_d_hold;

    unique case (r_state)
      ST_INIT: begin
        init_busy = 1'b1;
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = r_ptr;
        sram_d    = '0;
        w_ptr_nxt = r_ptr + PTR_ONE;
        if (r_ptr == PTR_LAST) begin
          init_done   = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (init_start) begin
          w_state_nxt = ST_INIT;
          w_ptr_nxt   = '0;
        end else if (rd_req && (!wr_req || r_last_wr)) begin
          // Ties go to the side that did not win last time.
          rd_gnt        = 1'b1;
          sram_cen      = 1'b0;
          sram_a        = rd_addr;
          w_last_wr_nxt = 1'b0;
        end else if (wr_req) begin
          wr_gnt        = 1'b1;
          sram_cen      = 1'b0;
          sram_gwen     = ~|wr_mask;
          sram_wen      = ~wr_mask;
          sram_a        = wr_addr;
          sram_d        = wr_data;
          w_last_wr_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // The macro presents Q in the cycle after the access, which is the rd_vld cycle.
  assign rd_vld  = r_rd_vld;
  assign rd_data = r_rd_vld ? sram_q : '0;

endmodule

// File: tb/tb_ct_f_spsram_arb_ctrl.sv
// Bench for ct_f_spsram_arb_ctrl: SRAM macro model, per-cycle reference model,
// directed corner cases, a vector table and randomized traffic.
module tb_ct_f_spsram_arb_ctrl;

  localparam int AW    = 9;
  localparam int DW    = 59;
  localparam int DEPTH = 512;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          init_start = 1'b0;
  logic          rd_req     = 1'b0;
  logic          wr_req     = 1'b0;
  logic [AW-1:0] rd_addr    = '0;
  logic [AW-1:0] wr_addr    = '0;
  logic [DW-1:0] wr_data    = '0;
  logic [DW-1:0] wr_mask    = '0;

  logic          init_busy, init_done, rd_gnt, rd_vld, wr_gnt, sram_cen, sram_gwen;
  logic [DW-1:0] rd_data, sram_wen, sram_d, sram_q;
  logic [AW-1:0] sram_a;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ct_f_spsram_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .forever_cpuclk(clk),
    .cpurst_b      (rst_n),
    .init_start    (init_start),
    .init_busy     (init_busy),
    .init_done     (init_done),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_gnt        (rd_gnt),
    .rd_vld        (rd_vld),
    .rd_data       (rd_data),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_mask       (wr_mask),
    .wr_gnt        (wr_gnt),
    .sram_a        (sram_a),
    .sram_cen      (sram_cen),
    .sram_gwen     (sram_gwen),
    .sram_wen      (sram_wen),
    .sram_d        (sram_d),
    .sram_q        (sram_q)
  );

  // Single-port macro: active-low enables, per-bit write enable, Q registered on read.
  logic [DW-1:0] sram_mem [DEPTH];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (sram_gwen) sram_q <= sram_mem[sram_a];
      else           sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected content array, clear counter and last-winner memory.
  logic          m_init, m_last_wr, m_pend;
  int            m_cnt;
  logic [DW-1:0] m_pend_data, m_d, e_wen;
  logic [AW-1:0] m_a;
  logic          e_rd, e_wr, e_cen, e_gwen;
  logic [DW-1:0] m_mem [DEPTH];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_init    = 1'b1;
      m_cnt     = 0;
      m_last_wr = 1'b1;
      m_pend    = 1'b0;
      m_a       = '0;
      m_d       = '0;
    end else begin
      e_rd = 1'b0; e_wr = 1'b0; e_cen = 1'b1; e_gwen = 1'b1; e_wen = '1;
      if (m_init) begin
        e_cen = 1'b0; e_gwen = 1'b0; e_wen = '0;
        m_a = AW'(m_cnt);
        m_d = '0;
      end else if (!init_start) begin
        e_rd = rd_req && (!wr_req || m_last_wr);
        e_wr = wr_req && !e_rd;
        if (e_rd) begin
          e_cen = 1'b0;
          m_a   = rd_addr;
        end
        if (e_wr) begin
          e_cen  = 1'b0;
          e_gwen = (wr_mask == '0);
          e_wen  = ~wr_mask;
          m_a    = wr_addr;
          m_d    = wr_data;
        end
      end
      check("m_busy",   64'(init_busy), 64'(m_init));
      check("m_done",   64'(init_done), 64'(m_init && m_cnt == DEPTH-1));
      check("m_rd_gnt", 64'(rd_gnt),    64'(e_rd));
      check("m_wr_gnt", 64'(wr_gnt),    64'(e_wr));
      check("m_cen",    64'(sram_cen),  64'(e_cen));
      check("m_gwen",   64'(sram_gwen), 64'(e_gwen));
      check("m_wen",    64'(sram_wen),  64'(e_wen));
      check("m_a",      64'(sram_a),    64'(m_a));
      check("m_d",      64'(sram_d),    64'(m_d));
      check("m_rd_vld", 64'(rd_vld),    64'(m_pend));
      if (m_pend) check("m_rd_data", 64'(rd_data), 64'(m_pend_data));

      m_pend = e_rd;
      if (e_rd) m_pend_data = m_mem[rd_addr];
      if (e_wr) m_mem[wr_addr] = (m_mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
      if (e_rd || e_wr) m_last_wr = e_wr;
      if (m_init) begin
        m_mem[m_cnt] = '0;
        if (m_cnt == DEPTH-1) begin
          m_init = 1'b0;
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end else if (init_start) begin
        m_init = 1'b1;
        m_cnt  = 0;
      end
    end
  end

  // Tasks start just after a rising edge and return just after a rising edge.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    wr_req = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    @(negedge clk);
    check("wr_gnt", 64'(wr_gnt), 64'(1));
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd_req = 1'b1; rd_addr = a;
    @(negedge clk);
    check({name, "_gnt"}, 64'(rd_gnt), 64'(1));
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    check({name, "_vld"}, 64'(rd_vld), 64'(1));
    check(name, 64'(rd_data), 64'(exp));
    @(posedge clk); #1;
  endtask

  // Full clear sweep with any request held; the request must be granted right after.
  task automatic init_sweep(input string name, input logic expect_rd);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check({name, "_a"},    64'(sram_a),    64'(i));
      check({name, "_busy"}, 64'(init_busy), 64'(1));
      check({name, "_done"}, 64'(init_done), 64'(i == DEPTH-1));
      check({name, "_gnt"},  64'(rd_gnt),    64'(0));
    end
    @(negedge clk);
    check({name, "_busy_fall"}, 64'(init_busy), 64'(0));
    check({name, "_first_gnt"}, 64'(rd_gnt),    64'(expect_rd));
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic rq;
    logic wq;
    logic e_rg;
    logic e_wg;
    logic e_cen;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic g_rd, g_wr;
    logic [DW-1:0] all1;
    all1 = '1;
    //                rq    wq    rgnt  wgnt  cen
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(init_busy), 64'(1));
    check("rst_done", 64'(init_done), 64'(0));
    check("rst_vld",  64'(rd_vld),    64'(0));
    check("rst_data", 64'(rd_data),   64'(0));
    check("rst_cen",  64'(sram_cen),  64'(0));
    check("rst_gwen", 64'(sram_gwen), 64'(0));
    check("rst_wen",  64'(sram_wen),  64'(0));
    check("rst_a",    64'(sram_a),    64'(0));
    check("rst_d",    64'(sram_d),    64'(0));
    check("rst_gnt",  64'(rd_gnt | wr_gnt), 64'(0));

    // Clear after reset release with a read held throughout.
    rd_req = 1'b1; rd_addr = 9'd0;
    @(posedge clk); #2 rst_n = 1'b1;
    init_sweep("t1", 1'b1);
    rd_req = 1'b0;
    @(negedge clk);
    check("t1_vld",  64'(rd_vld),  64'(1));
    check("t1_data", 64'(rd_data), 64'(0));
    @(posedge clk); #1;

    // Read-after-write on consecutive cycles.
    do_write(9'd5, 59'h123_4567_89AB_CDEF, all1);
    do_read("t2_raw", 9'd5, 59'h123_4567_89AB_CDEF);

    // Back-to-back reads.
    rd_req = 1'b1; rd_addr = 9'd5;
    @(posedge clk); #1 rd_addr = 9'd0;
    @(negedge clk);
    check("b2b_vld0",  64'(rd_vld),  64'(1));
    check("b2b_data0", 64'(rd_data), 64'(59'h123_4567_89AB_CDEF));
    @(posedge clk); #1 rd_req = 1'b0;
    @(negedge clk);
    check("b2b_vld1",  64'(rd_vld),  64'(1));
    check("b2b_data1", 64'(rd_data), 64'(0));
    @(posedge clk); #1;

    // Masked writes.
    do_write(9'd7, all1, all1);
    do_write(9'd7, '0, 59'h0FF);
    do_read("t4_mask", 9'd7, 59'h7FF_FFFF_FFFF_FF00);
    wr_req = 1'b1; wr_addr = 9'd7; wr_data = '0; wr_mask = '0;
    @(negedge clk);
    check("t4_m0_gnt",  64'(wr_gnt),    64'(1));
    check("t4_m0_gwen", 64'(sram_gwen), 64'(1));
    @(posedge clk); #1 wr_req = 1'b0;
    do_read("t4_m0_keep", 9'd7, 59'h7FF_FFFF_FFFF_FF00);

    // Arbitration table; the last grant before it is a write.
    do_write(9'd9, 59'h3C, all1);
    for (int i = 0; i < 10; i++) begin
      rd_req = vecs[i].rq; wr_req = vecs[i].wq;
      rd_addr = AW'(i); wr_addr = AW'(i + 16);
      wr_data = DW'(i * 3 + 1); wr_mask = all1;
      @(negedge clk);
      check($sformatf("tbl%0d_rgnt", i), 64'(rd_gnt),   64'(vecs[i].e_rg));
      check($sformatf("tbl%0d_wgnt", i), 64'(wr_gnt),   64'(vecs[i].e_wg));
      check($sformatf("tbl%0d_cen", i),  64'(sram_cen), 64'(vecs[i].e_cen));
      @(posedge clk); #1;
    end
    rd_req = 1'b0; wr_req = 1'b0;

    // init_start with a read pending and an earlier read still returning.
    do_write(9'd3, 59'h55, all1);
    rd_req = 1'b1; rd_addr = 9'd3;
    @(posedge clk); #1 init_start = 1'b1;
    @(negedge clk);
    check("t6_no_rgnt", 64'(rd_gnt),   64'(0));
    check("t6_no_wgnt", 64'(wr_gnt),   64'(0));
    check("t6_cen",     64'(sram_cen), 64'(1));
    check("t6_vld",     64'(rd_vld),   64'(1));
    check("t6_data",    64'(rd_data),  64'(59'h55));
    @(posedge clk); #1 init_start = 1'b0;
    init_sweep("t6", 1'b1);
    rd_req = 1'b0;
    @(negedge clk);
    check("t6_clr_vld",  64'(rd_vld),  64'(1));
    check("t6_clr_data", 64'(rd_data), 64'(0));
    @(posedge clk); #1;

    // Reset in the middle of a clear.
    rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sram_a == 9'd100) break;
    end
    check("t5_ptr100", 64'(sram_a), 64'(100));
    #1 rst_n = 1'b0;
    #1 check("t5_rst_a", 64'(sram_a), 64'(0));
    @(posedge clk); #2 rst_n = 1'b1;
    init_sweep("t5", 1'b0);

    // Reset while a read is returning drops rd_vld.
    rd_req = 1'b1; rd_addr = 9'd1;
    @(posedge clk); #1 rd_req = 1'b0;
    check("rst_run_vld_pre", 64'(rd_vld), 64'(1));
    #1 rst_n = 1'b0;
    #1 check("rst_run_vld_drop", 64'(rd_vld), 64'(0));
    @(posedge clk); #2 rst_n = 1'b1;
    init_sweep("t5b", 1'b0);

    // Randomized traffic, requests held until granted.
    for (int c = 0; c < 4000; c++) begin
      if (!rd_req && ($urandom_range(1, 0) == 1)) begin
        rd_req = 1'b1; rd_addr = AW'($urandom_range(15, 0));
      end
      if (!wr_req && ($urandom_range(1, 0) == 1)) begin
        wr_req  = 1'b1;
        wr_addr = AW'($urandom_range(15, 0));
        wr_data = DW'({$urandom(), $urandom()});
        case ($urandom_range(3, 0))
          0:       wr_mask = '0;
          1:       wr_mask = all1;
          default: wr_mask = DW'({$urandom(), $urandom()});
        endcase
      end
      init_start = ($urandom_range(599, 0) == 0);
      @(negedge clk);
      g_rd = rd_gnt; g_wr = wr_gnt;
      @(posedge clk); #1;
      if (g_rd) rd_req = 1'b0;
      if (g_wr) wr_req = 1'b0;
      init_start = 1'b0;
    end
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
